// File: rtl/stepper_seq_pkg.sv
// Shared constants for the stepper step sequencer: register map, CTRL/STATUS
// bit positions and the sequencer FSM state encoding.
package stepper_seq_pkg;

    localparam logic [2:0] ADDR_PERIOD    = 3'd0;
    localparam logic [2:0] ADDR_STEPS     = 3'd1;
    localparam logic [2:0] ADDR_CTRL      = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_REMAINING = 3'd4;
    localparam logic [2:0] ADDR_POSITION  = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/stepper_pulse_timer.sv
// Loadable down-counter; expire is high for the single cycle in which the count
// is 1, so a load of N keeps the owning state active for exactly N cycles.
module stepper_pulse_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/stepper_step_sequencer.sv
// Avalon-MM stepper axis sequencer: turns PERIOD/STEPS/dir into STEP/DIR pulse
// trains. Define STEPPER_POSITION_EN to add the signed POSITION register at address 5.
module stepper_step_sequencer
    import stepper_seq_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        step_out,
    output logic        dir_out,
    output logic        irq
);

    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(2 * PULSE_W);
    localparam logic [CNT_W-1:0] SETUP_C = CNT_W'(DIR_SETUP);

    // Low time, with the period clamped so the low phase is never shorter than the high phase.
    function automatic logic [CNT_W-1:0] low_cycles(input logic [CNT_W-1:0] per);
        return ((per > MIN_PER) ? per : MIN_PER) - PULSE_C;
    endfunction

    seq_state_t       state;
    logic [CNT_W-1:0] period_r, steps_r, remaining_r;
    logic             ctrl_dir_r, irq_en_r, done_r, abort_pend;
    logic             busy;

    logic             wr_en, start_req, abort_req, new_dir, hi_exit;
    logic             go_setup, go_hi, go_lo, go_done, go_idle, start_zero;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_value;

    assign wr_en     = chipselect && !write_n;
    assign abort_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
    assign start_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START]
                       && !writedata[CTRL_ABORT];
    assign new_dir   = writedata[CTRL_DIR];
    assign busy      = (state != ST_IDLE);
    assign hi_exit   = (state == ST_PULSE_HI) && tmr_expire;
    assign irq       = done_r && irq_en_r;

    always_comb begin
        go_setup   = 1'b0;
        go_hi      = 1'b0;
        go_lo      = 1'b0;
        go_done    = 1'b0;
        go_idle    = 1'b0;
        start_zero = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if (steps_r == '0)         start_zero = 1'b1;
                    else if (new_dir != dir_out) go_setup = 1'b1;
                    else                         go_hi    = 1'b1;
                end
            end
            ST_DIR_SETUP: begin
                if (abort_req)       go_done = 1'b1;
                else if (tmr_expire) go_hi   = 1'b1;
            end
            ST_PULSE_HI: begin
                // An abort never truncates a high pulse; it only redirects the exit.
                if (tmr_expire) begin
                    if (abort_req || abort_pend) go_done = 1'b1;
                    else                         go_lo   = 1'b1;
                end
            end
            ST_PULSE_LO: begin
                if (abort_req) begin
                    go_done = 1'b1;
                end else if (tmr_expire) begin
                    if (remaining_r != '0) go_hi   = 1'b1;
                    else                   go_done = 1'b1;
                end
            end
            ST_DONE: go_idle = 1'b1;
            default: go_idle = 1'b1;
        endcase
    end

    assign tmr_load  = go_setup || go_hi || go_lo;
    assign tmr_value = go_setup ? SETUP_C : (go_hi ? PULSE_C : low_cycles(period_r));

    stepper_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            period_r    <= '0;
            steps_r     <= '0;
            remaining_r <= '0;
            ctrl_dir_r  <= 1'b0;
            irq_en_r    <= 1'b0;
            done_r      <= 1'b0;
            abort_pend  <= 1'b0;
            step_out    <= 1'b0;
            dir_out     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_PERIOD: period_r <= writedata[CNT_W-1:0];
                    ADDR_STEPS:  steps_r  <= writedata[CNT_W-1:0];
                    ADDR_CTRL: begin
                        ctrl_dir_r <= writedata[CTRL_DIR];
                        irq_en_r   <= writedata[CTRL_IRQ_EN];
                    end
                    ADDR_STATUS: if (writedata[STAT_DONE]) done_r <= 1'b0;
                    default: ;
                endcase
            end
            // Completion is assigned after the W1C so a coincident set wins.
            if (start_zero || go_idle) done_r <= 1'b1;

            if (start_req && !busy)
                remaining_r <= steps_r;
            else if (hi_exit && remaining_r != '0)
                remaining_r <= remaining_r - CNT_W'(1);

            if (go_lo || go_done)
                abort_pend <= 1'b0;
            else if (state == ST_PULSE_HI && abort_req)
                abort_pend <= 1'b1;

            if (go_setup) begin
                state   <= ST_DIR_SETUP;
                dir_out <= new_dir;
            end else if (go_hi) begin
                state    <= ST_PULSE_HI;
                step_out <= 1'b1;
            end else if (go_lo) begin
                state    <= ST_PULSE_LO;
                step_out <= 1'b0;
            end else if (go_done) begin
                state    <= ST_DONE;
                step_out <= 1'b0;
            end else if (go_idle) begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef STEPPER_POSITION_EN
    localparam logic signed [CNT_W-1:0] ONE_S = 1;
    logic signed [CNT_W-1:0] position_r;

    always_ff @(posedge clk) begin
        if (reset)
            position_r <= '0;
        else if (wr_en && address == ADDR_POSITION)
            position_r <= signed'(writedata[CNT_W-1:0]);
        else if (hi_exit)
            position_r <= dir_out ? position_r + ONE_S : position_r - ONE_S;
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_PERIOD:    readdata = 32'(period_r);
            ADDR_STEPS:     readdata = 32'(steps_r);
            ADDR_CTRL:      readdata = {28'd0, irq_en_r, 1'b0, ctrl_dir_r, 1'b0};
            ADDR_STATUS:    readdata = {30'd0, done_r, busy};
            ADDR_REMAINING: readdata = 32'(remaining_r);
`ifdef STEPPER_POSITION_EN
            ADDR_POSITION:  readdata = 32'(position_r);
`endif
            default:        readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_stepper_step_sequencer.sv
// Self-checking bench for stepper_step_sequencer (PULSE_W=4, DIR_SETUP=5):
// register table, directed corner sequences and random moves against a timing model.
module tb_stepper_step_sequencer;

    localparam int PW = 4;
    localparam int DS = 5;
`ifdef STEPPER_POSITION_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif
    localparam logic [2:0] A_PER = 3'd0, A_STEPS = 3'd1, A_CTRL = 3'd2,
                           A_STAT = 3'd3, A_REM = 3'd4, A_POS = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        step_out, dir_out, irq;

    stepper_step_sequencer #(.CNT_W(32), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rises[$], falls[$], dchg[$];
    logic prev_step = 1'b0, prev_dir = 1'b0;
    always @(negedge clk) begin
        if (step_out && !prev_step) rises.push_back(cyc);
        if (!step_out && prev_step) falls.push_back(cyc);
        if (dir_out !== prev_dir)   dchg.push_back(cyc);
        prev_step <= step_out;
        prev_dir  <= dir_out;
    end

    int n_cmp = 0, n_bad = 0;
    int ws;
    bit model_dir = 1'b0;

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        ws = cyc;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_idle(input int budget, output int t);
        logic [31:0] s;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            rd(A_STAT, s);
            if (!s[0]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: busy still set after %0d cycles, required idle", budget);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Whole-move reference: rising edges at start + setup + k*eff, idle one cycle after the last low phase.
    task automatic run_move(input int period, input int steps, input bit dir, input bit ien);
        int eff, setup, s0, t;
        bit chg;
        logic [31:0] r;
        eff   = (period > 2 * PW) ? period : 2 * PW;
        chg   = (dir != model_dir);
        setup = chg ? DS : 0;
        wr(A_PER, period);
        wr(A_STEPS, steps);
        rises.delete(); falls.delete(); dchg.delete();
        wr(A_CTRL, 32'h1 | (32'(dir) << 1) | (32'(ien) << 3));
        s0 = ws;
        model_dir = dir;
        wait_idle(setup + steps * eff + 20, t);
        check("move_end_cycle", t, s0 + setup + steps * eff + 1);
        check("pulse_count", rises.size(), steps);
        for (int k = 0; k < steps; k++) begin
            check("rise_time", qget(rises, k), s0 + setup + k * eff);
            check("fall_time", qget(falls, k), s0 + setup + k * eff + PW);
        end
        check("dir_out", dir_out, dir);
        if (chg) check("dir_change_time", qget(dchg, 0), s0);
        else     check("dir_change_count", dchg.size(), 0);
        rd(A_REM, r);  check("remaining_end", r, 0);
        rd(A_STAT, r); check("status_end", r, 2);
        check("irq_end", irq, ien);
        wr(A_STAT, 32'h2);
        check("irq_cleared", irq, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] r;
        int          s0, t;

        tbl.push_back('{1'b1, A_PER,   32'h0000_1234, 32'h0});
        tbl.push_back('{1'b0, A_PER,   32'h0,         32'h0000_1234});
        tbl.push_back('{1'b1, A_STEPS, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{1'b0, A_STEPS, 32'h0,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, A_CTRL,  32'h0000_000A, 32'h0});
        tbl.push_back('{1'b0, A_CTRL,  32'h0,         32'h0000_000A});
        tbl.push_back('{1'b1, A_CTRL,  32'h0000_0004, 32'h0});
        tbl.push_back('{1'b0, A_CTRL,  32'h0,         32'h0});
        tbl.push_back('{1'b0, A_STAT,  32'h0,         32'h0});
        tbl.push_back('{1'b0, A_REM,   32'h0,         32'h0});
        tbl.push_back('{1'b1, 3'd6,    32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 3'd6,    32'h0,         32'h0});
        tbl.push_back('{1'b0, 3'd7,    32'h0,         32'h0});
        tbl.push_back('{1'b1, A_POS,   32'h0000_0009, 32'h0});
        tbl.push_back('{1'b0, A_POS,   32'h0,         POS_EN ? 32'h9 : 32'h0});
        tbl.push_back('{1'b1, A_STAT,  32'h0000_0002, 32'h0});
        tbl.push_back('{1'b0, A_STAT,  32'h0,         32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_step_out", step_out, 0);
        check("rst_dir_out", dir_out, 0);
        check("rst_irq", irq, 0);
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), r);
            check("rst_reg", r, 0);
        end

        // Register table
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
            else begin
                rd(tbl[i].addr, r);
                check("reg_vector", r, tbl[i].exp);
            end
        end
        check("dir_out_after_ctrl_write_idle", dir_out, 0);

        // Directed moves: nominal, clamped period, direction change
        run_move(20, 3, 1'b0, 1'b1);
        run_move(3, 2, 1'b0, 1'b0);
        run_move(20, 1, 1'b1, 1'b1);

        // Abort during the second high pulse
        wr(A_PER, 20);
        wr(A_STEPS, 10);
        rises.delete(); falls.delete();
        wr(A_CTRL, 32'hB);
        s0 = ws;
        repeat (21) @(negedge clk);
        wr(A_CTRL, 32'hE);
        wait_idle(60, t);
        check("abort_idle_cycle", t, s0 + 25);
        check("abort_pulse_count", rises.size(), 2);
        check("abort_fall_time", qget(falls, 1), s0 + 24);
        rd(A_REM, r);  check("abort_remaining", r, 8);
        rd(A_STAT, r); check("abort_status", r, 2);
        check("abort_irq", irq, 1);
        wr(A_STAT, 32'h2);

        // Abort and start in one write: nothing starts
        rises.delete();
        wr(A_CTRL, 32'h7);
        rd(A_STAT, r); check("abort_start_status", r, 0);
        repeat (4) @(negedge clk);
        check("abort_start_pulses", rises.size(), 0);

        // Completion coinciding with a done W1C: the set wins
        wr(A_PER, 8);
        wr(A_STEPS, 1);
        wr(A_CTRL, 32'h3);
        s0 = ws;
        repeat (8) @(negedge clk);
        wr(A_STAT, 32'h2);
        rd(A_STAT, r); check("set_wins_status", r, 2);
        wr(A_STAT, 32'h2);
        rd(A_STAT, r); check("w1c_status", r, 0);

        // Zero-length move
        rises.delete();
        wr(A_STEPS, 0);
        wr(A_CTRL, 32'hB);
        rd(A_STAT, r); check("zero_status", r, 2);
        check("zero_irq", irq, 1);
        repeat (4) @(negedge clk);
        check("zero_pulses", rises.size(), 0);
        wr(A_STAT, 32'h2);
        check("zero_irq_cleared", irq, 0);

        // Start, STEPS and dir written while busy
        wr(A_PER, 8);
        wr(A_STEPS, 3);
        rises.delete();
        wr(A_CTRL, 32'h3);
        s0 = ws;
        wr(A_STEPS, 1);
        wr(A_CTRL, 32'h1);
        check("busy_dir_out", dir_out, 1);
        wait_idle(60, t);
        check("busy_idle_cycle", t, s0 + 25);
        check("busy_pulse_count", rises.size(), 3);
        rd(A_CTRL, r);  check("busy_ctrl_reg", r, 0);
        rd(A_STEPS, r); check("busy_steps_reg", r, 1);
        wr(A_STAT, 32'h2);

        // Random moves against the timing model
        for (int i = 0; i < 8; i++)
            run_move(int'($urandom_range(1, 30)), int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset in the middle of a high pulse
        wr(A_PER, 20);
        wr(A_STEPS, 3);
        wr(A_CTRL, 32'h1 | (32'(model_dir) << 1));
        repeat (2) @(negedge clk);
        check("pre_reset_step", step_out, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_step_out", step_out, 0);
        check("reset_dir_out", dir_out, 0);
        address = A_STAT;
        #1;
        check("reset_status", readdata, 0);
        @(negedge clk);
        reset = 1'b0;
        model_dir = 1'b0;

        // Position: 5 forward then 2 back
        run_move(10, 5, 1'b1, 1'b0);
        run_move(10, 2, 1'b0, 1'b0);
        rd(A_POS, r);
        check("position", r, POS_EN ? 3 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stepper_step_sequencer.md
Name: stepper_step_sequencer

Overview:
- Avalon-MM slave that sequences one stepper axis: converts a programmed step period, step count and direction into STEP/DIR pulse trains with guaranteed pulse width and direction setup time.
- Sits between the HPS lightweight bridge and the axis driver pins.
- Replaces software-timed toggling of the plain speed output register.
- Raises an interrupt when a move completes.

Parameters:
- CNT_W, 32, width of period, step-count and remaining counters.
- PULSE_W, 100, STEP high time in clk cycles (>=1).
- DIR_SETUP, 50, cycles between a DIR change and the next STEP rising edge (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- step_out  out  1  STEP pulse to driver.
- dir_out  out  1  direction to driver (1 = positive).
- irq  out  1  level interrupt = done & irq_en.

Behaviour:
- One clock, single clock domain. Reset is synchronous and active-high.
- Reset values: step_out=0, dir_out=0, irq=0, all registers 0, FSM in IDLE. Reset mid-pulse drops step_out on the next edge; no completion of the current pulse.
- Register map (word addresses):
  - 0 PERIOD, RW: cycles between STEP rising edges.
  - 1 STEPS, RW: move length.
  - 2 CTRL: bit0 start (write-1 strobe, reads 0); bit1 dir; bit2 abort (strobe, reads 0); bit3 irq_en.
  - 3 STATUS: bit0 busy (RO); bit1 done (write-1-to-clear).
  - 4 REMAINING, RO.
  - Unmapped addresses read 0 and ignore writes.
- Effective period: eff = max(PERIOD, 2*PULSE_W). Low time = eff - PULSE_W cycles.
- FSM:
  - IDLE: on start with busy=0, load REMAINING=STEPS and latch dir. If STEPS==0, set done and stay IDLE, with no pulse. Else go to DIR_SETUP if the latched dir differs from dir_out, otherwise go directly to PULSE_HI.
  - DIR_SETUP: dir_out takes the new value on entry. Hold DIR_SETUP cycles, then PULSE_HI.
  - PULSE_HI: step_out=1 for exactly PULSE_W cycles. On exit, REMAINING decrements.
  - PULSE_LO: step_out=0 for eff-PULSE_W cycles. Then PULSE_HI if REMAINING>0, otherwise DONE.
  - DONE: one cycle; set done, go to IDLE.
- busy=1 in every state except IDLE.
- First STEP rising edge: exactly 1 cycle after the start write with no dir change; 1+DIR_SETUP cycles with a dir change.
- PERIOD or STEPS written while busy: PERIOD takes effect at the next PULSE_LO load. STEPS affects only the next start.
- A CTRL dir write while busy updates the register bit only; dir_out is unaffected until the next start.
- Start while busy is ignored.
- Abort:
  - In PULSE_HI, finish the current high pulse (no runt pulse), then go to DONE.
  - In DIR_SETUP or PULSE_LO, go to DONE next cycle.
  - REMAINING keeps the value of un-issued steps.
  - Abort and start in the same write: abort wins.
- Done-set and W1C in the same cycle: set wins.
- Counters are unsigned CNT_W, with no wrap: REMAINING never decrements below 0.

Optional Feature:
- STEPPER_POSITION_EN defined: adds address 5 POSITION, a signed CNT_W register.
  - +1 or -1 per completed PULSE_HI, according to dir_out; wraps two's-complement.
  - Writable for homing. A write in the same cycle as an increment: the write wins.
- Undefined: address 5 reads 0, and no position logic is synthesized.

Decomposition:
- Package stepper_seq_pkg: register address constants, CTRL/STATUS bit indices, FSM state enum (IDLE, DIR_SETUP, PULSE_HI, PULSE_LO, DONE).
- One sub-module, stepper_pulse_timer: loadable CNT_W down-counter with load/value inputs and a one-cycle expire output. Reused for the setup, high and low intervals.

Test Plan:
- PULSE_W=4, PERIOD=20, STEPS=3, dir unchanged, start -> 3 pulses, each 4 cycles high, rising edges 20 cycles apart; done=1, irq=1 with irq_en; REMAINING=0.
- PERIOD=3 (< 2*PULSE_W=8), STEPS=2 -> rising edges 8 cycles apart (clamped).
- dir 0->1 with DIR_SETUP=5 -> dir_out rises 1 cycle after start; first STEP rises 5 cycles later.
- STEPS=10, abort during the 2nd high pulse -> that pulse is still 4 cycles; no further pulses; REMAINING=8; done=1.
- STEPS=0, start -> no STEP edge, done=1 next cycle; start while busy is ignored; W1C on done clears irq.
- Reset asserted mid-PULSE_HI -> step_out=0 and busy=0 after the next edge. With STEPPER_POSITION_EN: 5 steps positive, then 2 negative -> POSITION=3.
